// File: rtl/sig_complement_pipe.sv
// sig_complement_pipe: pipelined two's-complement unit for the FP add/sub
// significand path. Per transaction it passes, negates, takes the absolute
// value of, or conditionally negates the extended significand, and reports
// sign, overflow (negating the most-negative value) and zero flags alongside
// a sideband tag. A global-stall valid/ready handshake lets the downstream
// adder hold the whole pipe.
//
// Optional build macro SIG_COMPLEMENT_SAT_EN: when defined, an overflowing
// negation saturates to the maximum positive value instead of wrapping.
module sig_complement_pipe #(
  parameter  int SIG_BITS = 23,
  parameter  int STAGES   = 2,
  parameter  int TAG_BITS = 4,
  localparam int W        = SIG_BITS + 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          mode,
  input  logic                comp,
  input  logic [W-1:0]        operand,
  input  logic [TAG_BITS-1:0] tag_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W-1:0]        result,
  output logic                sign_out,
  output logic                ovf,
  output logic                zero,
  output logic [TAG_BITS-1:0] tag_out
);

  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
`ifdef SIG_COMPLEMENT_SAT_EN
  localparam logic [W-1:0] MAX_POS  = {1'b0, {(W-1){1'b1}}};
`endif

  logic                adv_s;
  logic                neg_s;
  logic [W-1:0]        inv_s;
  logic                ovf_s;
  logic                sign_s;

  // Values presented to the last stage by whatever precedes it
  logic                last_v_s;
  logic [W-1:0]        sum_s;
  logic                last_ovf_s;
  logic                last_sign_s;
  logic [TAG_BITS-1:0] last_tag_s;
  logic [W-1:0]        fin_s;

  // Global stall: everything advances unless a result is waiting unread
  assign adv_s    = !out_valid | out_ready;
  assign in_ready = adv_s;

  // Decode the mode into a negate decision plus the per-transaction flags
  always_comb begin
    neg_s  = 1'b0;
    inv_s  = operand;
    case (mode)
      2'b00:   neg_s = 1'b0;
      2'b01:   neg_s = 1'b1;
      2'b10:   neg_s = operand[W-1];
      2'b11:   neg_s = comp;
      default: neg_s = 1'b0;
    endcase
    if (neg_s) begin
      inv_s = ~operand;
    end else begin
      inv_s = operand;
    end
    ovf_s  = neg_s & (operand == MOST_NEG);
    sign_s = (mode == 2'b10) & operand[W-1];
  end

  if (STAGES == 1) begin : g_one
    // Single stage: the whole +1 happens ahead of the output register
    assign last_v_s    = in_valid;
    assign sum_s       = inv_s + {{(W-1){1'b0}}, neg_s};
    assign last_ovf_s  = ovf_s;
    assign last_sign_s = sign_s;
    assign last_tag_s  = tag_in;
  end else begin : g_two
    // Two stages: the +1 ripples through the low half first, the carry is
    // registered, and the upper half absorbs it in the output stage.
    localparam int LO = (W + 1) / 2;
    localparam int HI = W - LO;

    logic                v1_r;
    logic [HI-1:0]       hi1_r;
    logic [LO-1:0]       lo1_r;
    logic                c1_r;
    logic                ovf1_r;
    logic                sign1_r;
    logic [TAG_BITS-1:0] tag1_r;
    logic [LO:0]         lo_sum_s;

    assign lo_sum_s = {1'b0, inv_s[LO-1:0]} + {{LO{1'b0}}, neg_s};

    // Stage 1: valid follows the input on advance; payload loads only when valid
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v1_r    <= 1'b0;
        hi1_r   <= {HI{1'b0}};
        lo1_r   <= {LO{1'b0}};
        c1_r    <= 1'b0;
        ovf1_r  <= 1'b0;
        sign1_r <= 1'b0;
        tag1_r  <= {TAG_BITS{1'b0}};
      end else if (adv_s) begin
        v1_r <= in_valid;
        if (in_valid) begin
          hi1_r   <= inv_s[W-1:LO];
          lo1_r   <= lo_sum_s[LO-1:0];
          c1_r    <= lo_sum_s[LO];
          ovf1_r  <= ovf_s;
          sign1_r <= sign_s;
          tag1_r  <= tag_in;
        end
      end
    end

    assign last_v_s    = v1_r;
    assign sum_s       = {hi1_r + {{(HI-1){1'b0}}, c1_r}, lo1_r};
    assign last_ovf_s  = ovf1_r;
    assign last_sign_s = sign1_r;
    assign last_tag_s  = tag1_r;
  end

  // Final value: wrapped sum, or clamp to max positive on overflow when enabled
  always_comb begin
    fin_s = sum_s;
`ifdef SIG_COMPLEMENT_SAT_EN
    if (last_ovf_s) begin
      fin_s = MAX_POS;
    end else begin
      fin_s = sum_s;
    end
`endif
  end

  // Output stage: registers result and flags; holds everything while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= {W{1'b0}};
      sign_out  <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      tag_out   <= {TAG_BITS{1'b0}};
    end else if (adv_s) begin
      out_valid <= last_v_s;
      if (last_v_s) begin
        result   <= fin_s;
        sign_out <= last_sign_s;
        ovf      <= last_ovf_s;
        zero     <= (fin_s == {W{1'b0}});
        tag_out  <= last_tag_s;
      end
    end
  end

endmodule

// File: tb/tb_sig_complement_pipe.sv
// Self-checking bench for sig_complement_pipe: a 2-stage instance (main DUT)
// and a 1-stage instance sharing the same input stimulus.
module tb_sig_complement_pipe;

  localparam int W  = 27;
  localparam int TB = 4;
  localparam int OW = 1 + W + 3 + TB;
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAX_POS  = {1'b0, {(W-1){1'b1}}};

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    mode;
  logic          comp;
  logic [W-1:0]  operand;
  logic [TB-1:0] tag_in;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          sign_out;
  logic          ovf;
  logic          zero;
  logic [TB-1:0] tag_out;

  logic          in_ready1;
  logic          out_valid1;
  logic [W-1:0]  result1;
  logic          sign_out1;
  logic          ovf1;
  logic          zero1;
  logic [TB-1:0] tag_out1;

  logic [OW-1:0] outvec;
  logic [OW-1:0] outvec1;

  int checks   = 0;
  int failures = 0;

  assign outvec  = {out_valid, result, sign_out, ovf, zero, tag_out};
  assign outvec1 = {out_valid1, result1, sign_out1, ovf1, zero1, tag_out1};

  sig_complement_pipe #(.SIG_BITS(23), .STAGES(2), .TAG_BITS(TB)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .comp(comp), .operand(operand), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .sign_out(sign_out), .ovf(ovf), .zero(zero), .tag_out(tag_out)
  );

  sig_complement_pipe #(.SIG_BITS(23), .STAGES(1), .TAG_BITS(TB)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .mode(mode), .comp(comp), .operand(operand), .tag_in(tag_in),
    .out_valid(out_valid1), .out_ready(1'b1), .result(result1),
    .sign_out(sign_out1), .ovf(ovf1), .zero(zero1), .tag_out(tag_out1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {result, sign, ovf, zero} straight from the arithmetic rules
  function automatic logic [W+2:0] model(input logic [1:0] m, input logic c,
                                          input logic [W-1:0] op);
    logic         n;
    logic         o;
    logic [W-1:0] r;
    n = (m == 2'd1) || (m == 2'd2 && op[W-1]) || (m == 2'd3 && c);
    r = n ? -op : op;
    o = n && (op == MOST_NEG);
`ifdef SIG_COMPLEMENT_SAT_EN
    if (o) r = MAX_POS;
`endif
    return {r, (m == 2'd2) && op[W-1], o, r == {W{1'b0}}};
  endfunction

  function automatic logic [W-1:0] rand_op();
    logic [31:0] r;
    r = $urandom;
    case (r[2:0])
      3'd0:    return {W{1'b0}};
      3'd1:    return MOST_NEG;
      3'd2:    return {W{1'b1}};
      3'd3:    return MAX_POS;
      default: begin
        r = $urandom;
        return r[W-1:0];
      end
    endcase
  endfunction

  task automatic test_reset();
    #2;
    checks++;
    if (outvec !== {OW{1'b0}}) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected %h", outvec, {OW{1'b0}});
    end
    checks++;
    if (in_ready !== 1'b1 || in_ready1 !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b/%b expected 1/1", in_ready, in_ready1);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One isolated transaction; checks 1-stage latency, 2-stage latency and values
  task automatic run_one(input string nm, input logic [1:0] m, input logic c,
                         input logic [W-1:0] op, input logic [W-1:0] er,
                         input logic es, input logic eo, input logic ez);
    logic [TB-1:0] tg;
    logic [OW-1:0] ex;
    tg = TB'($urandom_range(0, 15));
    ex = {1'b1, er, es, eo, ez, tg};
    @(negedge clk);
    in_valid = 1'b1; mode = m; comp = c; operand = op; tag_in = tg; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (outvec1 !== ex) begin
      failures++;
      $display("FAIL %s_stages1: got %h expected %h", nm, outvec1, ex);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_early: got out_valid=%b expected 0", nm, out_valid);
    end
    @(negedge clk);
    checks++;
    if (outvec !== ex) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, outvec, ex);
    end
  endtask

  task automatic test_neg();
    run_one("neg_one",   2'b01, 1'b0, 27'h0000001, 27'h7FFFFFF, 1'b0, 1'b0, 1'b0);
    run_one("neg_split", 2'b01, 1'b0, 27'h0002000, 27'h7FFE000, 1'b0, 1'b0, 1'b0);
    run_one("pass_min",  2'b00, 1'b1, 27'h4000000, 27'h4000000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_ovf();
`ifdef SIG_COMPLEMENT_SAT_EN
    run_one("neg_ovf", 2'b01, 1'b0, 27'h4000000, 27'h3FFFFFF, 1'b0, 1'b1, 1'b0);
`else
    run_one("neg_ovf", 2'b01, 1'b0, 27'h4000000, 27'h4000000, 1'b0, 1'b1, 1'b0);
`endif
  endtask

  task automatic test_abs_cond();
    run_one("abs_neg",   2'b10, 1'b0, 27'h7FFFFFF, 27'h0000001, 1'b1, 1'b0, 1'b0);
    run_one("abs_pos",   2'b10, 1'b1, 27'h0000005, 27'h0000005, 1'b0, 1'b0, 1'b0);
    run_one("cond_zero", 2'b11, 1'b0, 27'h0000000, 27'h0000000, 1'b0, 1'b0, 1'b1);
    run_one("cond_neg",  2'b11, 1'b1, 27'h0000003, 27'h7FFFFFD, 1'b0, 1'b0, 1'b0);
  endtask

  // Streams n transactions through the 2-stage DUT against an in-order scoreboard
  task automatic stream(input string nm, input int n, input bit rnd);
    logic [OW-1:0] q[$];
    logic [OW-1:0] prev;
    logic [OW-1:0] ex;
    bit            prev_stall;
    int            pushed;
    int            popped;
    int            cyc;
    int            first_out;
    pushed = 0; popped = 0; cyc = 0; first_out = -1; prev_stall = 1'b0; prev = '0;
    while ((pushed < n || popped < n) && cyc < 600) begin
      @(negedge clk);
      if (prev_stall) begin
        checks++;
        if (outvec !== prev) begin
          failures++;
          $display("FAIL %s_hold: got %h expected %h", nm, outvec, prev);
        end
      end
      in_valid = (pushed < n) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      mode     = 2'($urandom_range(0, 3));
      comp     = 1'($urandom_range(0, 1));
      operand  = rand_op();
      tag_in   = TB'($urandom_range(0, 15));
      if (rnd) begin
        out_ready = ($urandom_range(0, 2) != 0);
      end else begin
        if (first_out < 0 && out_valid) first_out = cyc;
        out_ready = !(first_out >= 0 && cyc - first_out < 3);
      end
      #1;
      if (out_valid && !out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin
          failures++;
          $display("FAIL %s_stall_ready: got in_ready=%b expected 0", nm, in_ready);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL %s_spurious: got %h expected no output", nm, outvec);
        end else begin
          ex = q.pop_front();
          if (outvec !== ex) begin
            failures++;
            $display("FAIL %s_data: got %h expected %h", nm, outvec, ex);
          end
        end
        popped++;
      end
      if (in_valid && in_ready) begin
        q.push_back({1'b1, model(mode, comp, operand), tag_in});
        pushed++;
      end
      prev_stall = out_valid && !out_ready;
      prev       = outvec;
      cyc++;
    end
    checks++;
    if (pushed != n || popped != n || q.size() != 0) begin
      failures++;
      $display("FAIL %s_count: got pushed=%0d popped=%0d expected %0d each", nm, pushed, popped, n);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    stream("b2b", 8, 1'b0);
  endtask

  task automatic test_random();
    stream("rand", 80, 1'b1);
  endtask

  task automatic test_reset_midstream();
    logic [OW-1:0] ex;
    @(negedge clk);
    in_valid = 1'b1; mode = 2'b01; comp = 1'b0; operand = 27'h0000007; tag_in = 4'h3;
    out_ready = 1'b1;
    @(negedge clk);
    operand = 27'h0000009; tag_in = 4'h4;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL midrst_inflight: got out_valid=%b expected 1", out_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (outvec !== {OW{1'b0}} || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL midrst_clear: got %h/%b expected %h/1", outvec, in_ready, {OW{1'b0}});
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; mode = 2'b01; operand = 27'h0000001; tag_in = 4'h5;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    ex = {1'b1, 27'h7FFFFFF, 1'b0, 1'b0, 1'b0, 4'h5};
    checks++;
    if (outvec !== ex) begin
      failures++;
      $display("FAIL midrst_first: got %h expected %h", outvec, ex);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL midrst_stale: got out_valid=%b expected 0 (cycle %0d)", out_valid, i);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; mode = 2'b00; comp = 1'b0;
    operand = {W{1'b0}}; tag_in = {TB{1'b0}}; out_ready = 1'b1;
    test_reset();
    test_neg();
    test_ovf();
    test_abs_cond();
    test_back_to_back();
    test_random();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
